// File: rtl/hms_preset_loader.sv
// hms_preset_loader: drives a 24-hour preset into the HMS clock, passing user buttons through while idle.
// Define HMS_LOADER_RANGE_CHECK_EN to reject out-of-range presets with an err pulse.
module hms_preset_loader (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] hrs24,
   input  logic [5:0] min_in,
   input  logic [5:0] sec_in,
   input  logic       btn_ss,
   input  logic       btn_sel,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic       ss,
   output logic       sel,
   output logic       inc,
   output logic       dec,
   output logic       load,
   output logic [2:0] addr,
   output logic [5:0] din,
   output logic       busy,
   output logic       done,
   output logic       err
);
   typedef enum logic [2:0] {IDLE, EXIT, ENTER, LD_H, LD_M, LD_S, LEAVE, DONE} state_t;
   typedef enum logic [1:0] {M_RUN, M_PL, M_SET} mode_t;
   state_t     state, nxt;
   mode_t      mode, mode_nxt;
   logic [4:0] h_q;
   logic [5:0] m_q, s_q;
   logic       idle, pass, bad;
`ifdef HMS_LOADER_RANGE_CHECK_EN
   logic       err_q;
   assign bad = (hrs24 > 5'd23) || (min_in > 6'd59) || (sec_in > 6'd59);
   assign err = err_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_q <= 1'b0;
      else err_q <= idle & start & bad;
`else
   assign bad = 1'b0;
   assign err = 1'b0;
`endif
   // Buttons reach the clock only in idle cycles without a start request.
   always_comb begin
      idle = state == IDLE;
      pass = idle & ~start & rst_n;
      ss   = pass ? btn_ss : (state inside {EXIT, ENTER, LEAVE});
      sel  = pass & btn_sel;
      inc  = pass & btn_inc;
      dec  = pass & btn_dec;
      load = state inside {LD_H, LD_M, LD_S};
      addr = state == LD_H ? 3'd3 : state == LD_M ? 3'd2 : state == LD_S ? 3'd1 : 3'd0;
      din  = state == LD_H ? {1'b0, h_q} : state == LD_M ? m_q : state == LD_S ? s_q : 6'd0;
      busy = ~idle & (state != DONE);
      done = state == DONE;
      nxt  = idle ? ((start & ~bad) ? (mode != M_RUN ? EXIT : ENTER) : IDLE)
                  : state == DONE ? IDLE : state_t'(state + 3'd1);
   end
   // Mirror tracks the clock mode from the controls actually driven.
   always_comb begin
      mode_nxt = mode == M_RUN ? (ss ? M_PL : M_RUN)
               : mode == M_PL  ? (ss ? M_RUN : sel ? M_SET : M_PL)
               : (sel ? M_SET : ss ? M_RUN : M_SET);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         mode  <= M_RUN;
         h_q   <= 5'd0;
         m_q   <= 6'd0;
         s_q   <= 6'd0;
      end else begin
         state <= nxt;
         mode  <= mode_nxt;
         if (idle & start) begin
            h_q <= hrs24;
            m_q <= min_in;
            s_q <= sec_in;
         end
      end
endmodule
